// File: rtl/operand_stream_buffer.sv
// ---------------------------------------------------------------------------
// operand_stream_buffer
//   Elastic valid/ready stage in front of one accelerator operand port.
//   Host words are buffered in a DEPTH-entry FIFO and presented with a
//   per-word zero flag (lets the chip skip MACs) and an end-of-frame marker
//   derived from a pop counter modulo FRAME_LEN.
//
//   Build option: OPERAND_ZERO_FLAG_EN
//     defined   - zero bit stored per entry, driven on out_zero_flag
//     undefined - no zero bit stored, out_zero_flag tied to 0
//
// Ports
//   clk            system clock
//   arst_n_in      asynchronous reset, active low
//   flush          synchronous clear of FIFO and frame counter (wins over push/pop)
//   in_data        host operand word
//   in_valid       host word valid
//   in_ready       buffer can accept a word (= not full, no path from out_ready)
//   out_data       FIFO head word (0 while empty)
//   out_zero_flag  head word == 0
//   out_valid      FIFO not empty
//   out_ready      chip accepts the head word
//   out_last       head word is the last word of the current frame
//   level          FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module operand_stream_buffer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned FRAME_LEN  = 576
) (
   input  logic                           clk,
   input  logic                           arst_n_in,
   input  logic                           flush,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_zero_flag,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef OPERAND_ZERO_FLAG_EN
   localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
`else
   localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q,  level_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;

   logic               empty_c;
   logic               full_c;
   logic               push_c;
   logic               pop_c;
   logic               last_c;
   logic [ENTRY_W-1:0] wr_entry_c;
   logic [ENTRY_W-1:0] head_c;

   // Occupancy-derived status; ready never looks at out_ready
   assign empty_c = (level_q == '0);
   assign full_c  = (level_q == LVL_W'(DEPTH));
   assign push_c  = in_valid && !full_c;
   assign pop_c   = !empty_c && out_ready;
   assign last_c  = !empty_c && (cnt_q == CNT_W'(FRAME_LEN - 1));

   // Entry packing: optional zero bit above the data word
`ifdef OPERAND_ZERO_FLAG_EN
   assign wr_entry_c = {(in_data == '0), in_data};
`else
   assign wr_entry_c = in_data;
`endif

   assign head_c = mem_q[rd_ptr_q];

   // Next-state for pointers, level and frame counter; flush dominates
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         cnt_d    = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
         end
         if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
         end else if (!push_c && pop_c) begin
            level_d = level_q - LVL_W'(1);
         end
      end
   end

   // Control state
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage: contents are only observable through the valid-gated head
   always_ff @(posedge clk) begin
      if (push_c && !flush) begin
         mem_q[wr_ptr_q] <= wr_entry_c;
      end
   end

   // Output view of the head entry; forced to 0 while empty
   assign in_ready  = !full_c;
   assign out_valid = !empty_c;
   assign out_last  = last_c;
   assign level     = level_q;
   assign out_data  = empty_c ? '0 : head_c[DATA_WIDTH-1:0];
`ifdef OPERAND_ZERO_FLAG_EN
   assign out_zero_flag = !empty_c && head_c[DATA_WIDTH];
`else
   assign out_zero_flag = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_operand_stream_buffer
//   Randomised and directed stimulus for operand_stream_buffer, checked every
//   cycle against a queue-based reference model of the buffer.
//   Configuration under test: DATA_WIDTH=16, DEPTH=4, FRAME_LEN=3.
// ---------------------------------------------------------------------------
module tb_operand_stream_buffer;

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FL    = 3;
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          arst_n_in;
   logic          flush;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_zero_flag;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [LW-1:0] level;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model: queue of buffered words and pops-in-frame count
   logic [DW-1:0] mdl_q[$];
   int unsigned   mdl_cnt = 0;

   always #5 clk = ~clk;

   operand_stream_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .FRAME_LEN  (FL)
   ) dut (
      .clk           (clk),
      .arst_n_in     (arst_n_in),
      .flush         (flush),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_zero_flag (out_zero_flag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .level         (level)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model's current state
   task automatic check_outputs();
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic          e_zero;
      logic          e_last;
      e_valid = (mdl_q.size() != 0);
      e_data  = e_valid ? mdl_q[0] : '0;
`ifdef OPERAND_ZERO_FLAG_EN
      e_zero  = e_valid && (mdl_q[0] == '0);
`else
      e_zero  = 1'b0;
`endif
      e_last  = e_valid && (mdl_cnt == FL - 1);
      check_eq("level",     32'(level),         32'(mdl_q.size()));
      check_eq("in_ready",  32'(in_ready),      32'(mdl_q.size() < DEPTH));
      check_eq("out_valid", 32'(out_valid),     32'(e_valid));
      check_eq("out_data",  32'(out_data),      32'(e_data));
      check_eq("zero_flag", 32'(out_zero_flag), 32'(e_zero));
      check_eq("out_last",  32'(out_last),      32'(e_last));
   endtask

   // One clock: check state left by the previous edge, drive inputs,
   // then advance the model by what the coming edge should do
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
      bit do_push;
      bit do_pop;
      @(negedge clk);
      check_outputs();
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      if (f) begin
         mdl_q.delete();
         mdl_cnt = 0;
      end else begin
         do_push = v && (mdl_q.size() < DEPTH);
         do_pop  = r && (mdl_q.size() != 0);
         if (do_pop) begin
            mdl_cnt = (mdl_cnt == FL - 1) ? 0 : mdl_cnt + 1;
            void'(mdl_q.pop_front());
         end
         if (do_push) mdl_q.push_back(d);
      end
   endtask

   // Asynchronous reset pulse dropped mid-cycle, checked immediately
   task automatic pulse_reset();
      @(negedge clk);
      check_outputs();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      arst_n_in = 1'b0;
      mdl_q.delete();
      mdl_cnt = 0;
      #1;
      check_outputs();
      @(negedge clk);
      check_outputs();
      arst_n_in = 1'b1;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
   endfunction

   initial begin
      arst_n_in = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      check_outputs();
      #12;
      check_outputs();
      @(negedge clk);
      arst_n_in = 1'b1;

      // Idle, then single push with stalled output
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Fill to full, offer a 5th word while popping, then drain
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 16'h0001, 1'b0, 1'b0);
      cycle(1'b1, 16'h0000, 1'b0, 1'b0);
      cycle(1'b1, 16'h0003, 1'b0, 1'b0);
      cycle(1'b1, 16'h0004, 1'b0, 1'b0);
      cycle(1'b1, 16'h0005, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Stall: head must hold while out_ready is low
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Continuous push and pop of 100 random words
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 100; i++) cycle(1'b1, rnd_word(), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Frame marker across 7 words from a fresh frame
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b1, DW'(i + 1), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Flush with a simultaneous push and pop
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h00A0 + i), 1'b0, 1'b0);
      cycle(1'b1, 16'h0BAD, 1'b1, 1'b1);
      cycle(1'b1, 16'h0C01, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Reset with level=2 and frame count=2, then a fresh frame
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 16'h0011, 1'b0, 1'b0);
      cycle(1'b1, 16'h0022, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, 16'h0033, 1'b0, 1'b0);
      cycle(1'b1, 16'h0044, 1'b0, 1'b0);
      pulse_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            cycle(1'($urandom_range(0, 99) < 60), rnd_word(),
                  1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 2));
         end
      end
      cycle(1'b0, '0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
